note_playback_reader: RTL and testbench

//  Read side of the 16-entry note memory. On start, walks addresses 0..last_addr,

---
 rtl/note_playback_reader.sv | 118 +++++++++++
 tb/tb_note_playback_reader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/note_playback_reader.sv
// Read side of the note memory: walks slots 0..last_addr, fetches each note word over a
// 1-cycle-latency read port and plays it for a fixed time followed by a silent gap.
module note_playback_reader #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned NOTE_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [5:0]        mem_q,
    output logic [3:0]        note,
    output logic [1:0]        octave,
    output logic              note_valid,
    output logic              note_strobe,
    output logic [ADDR_W-1:0] play_index,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StPlay, StGap} state_t;

    localparam logic [CNT_W-1:0] NoteLoad = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLoad  = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam bit               HasGap   = (GAP_CYCLES != 0);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] last_q;
    logic              cnt_zero;
    logic              slot_end;
    logic              is_note;

    assign cnt_zero = (cnt == '0);
    // Last cycle of a slot: end of GAP, or end of PLAY when there is no gap.
    assign slot_end = cnt_zero && ((state == StPlay && !HasGap) || state == StGap);
    assign is_note  = (mem_q[3:0] < 4'd12);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            cnt         <= '0;
            last_q      <= '0;
            mem_addr    <= '0;
            note        <= '0;
            octave      <= '0;
            play_index  <= '0;
            note_valid  <= 1'b0;
            note_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            note_strobe <= 1'b0;
            done        <= 1'b0;
            if (stop && state != StIdle) begin
                state      <= StIdle;
                note_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (start && !stop) begin
                            mem_addr <= '0;
                            last_q   <= last_addr;
                            busy     <= 1'b1;
                            state    <= StFetch;
                        end
                    end
                    StFetch: state <= StWait;
                    StWait: begin
                        note        <= mem_q[3:0];
                        octave      <= mem_q[5:4];
                        play_index  <= mem_addr;
                        note_valid  <= is_note;
                        note_strobe <= is_note;
                        cnt         <= NoteLoad;
                        state       <= StPlay;
                    end
                    StPlay: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            note_valid <= 1'b0;
                            cnt        <= GapLoad;
                            state      <= StGap;
                        end
                    end
                    StGap: begin
                        if (!cnt_zero) begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
                // Slot advance overrides the per-state next state above.
                if (slot_end) begin
                    if (mem_addr != last_q) begin
                        mem_addr <= mem_addr + 1'b1;
                        state    <= StFetch;
                    end else if (loop) begin
                        mem_addr <= '0;
                        state    <= StFetch;
                    end else begin
                        state <= StIdle;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_note_playback_reader.sv
// Directed bench for note_playback_reader with a strobe scoreboard and a registered memory model.
module tb_note_playback_reader;

    logic       clk = 1'b0;
    logic       reset, start, stop, loop;
    logic [3:0] last_addr, mem_addr, play_index, note;
    logic [5:0] mem_q;
    logic [1:0] octave;
    logic       note_valid, note_strobe, busy, done;
    logic [5:0] mem [16];

    always #5 clk = ~clk;
    always @(posedge clk) mem_q <= mem[mem_addr];

    note_playback_reader #(
        .ADDR_W(4), .CNT_W(24), .NOTE_CYCLES(4), .GAP_CYCLES(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .loop(loop),
        .last_addr(last_addr), .mem_addr(mem_addr), .mem_q(mem_q), .note(note),
        .octave(octave), .note_valid(note_valid), .note_strobe(note_strobe),
        .play_index(play_index), .busy(busy), .done(done)
    );

    typedef struct {int cyc; logic [3:0] idx; logic [5:0] word;} exp_t;
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push(input int c, input int i);
        sb.push_back('{c, 4'(i), mem[i]});
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
        check({tag, "_note"}, 32'(note), 32'(0));
        check({tag, "_octave"}, 32'(octave), 32'(0));
        check({tag, "_play_index"}, 32'(play_index), 32'(0));
        check({tag, "_note_valid"}, 32'(note_valid), 32'(0));
        check({tag, "_note_strobe"}, 32'(note_strobe), 32'(0));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_done"}, 32'(done), 32'(0));
    endtask

    // Advance to end_cyc checking busy/done windows, strobes against the scoreboard and
    // the number of note_valid cycles. disturb pulses start at 5 and moves last_addr at 6.
    task automatic run(input int end_cyc, input int busy_lo, input int busy_hi,
                       input int done_at, input int nv_exp, input bit disturb);
        int   nv = 0;
        exp_t e;
        while (cyc < end_cyc) begin
            if (cyc >= 1) start = disturb && (cyc == 5);
            if (disturb && cyc == 6) last_addr = 4'd0;
            tick();
            check("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            check("done", 32'(done), 32'(cyc == done_at));
            if (cyc == 1 && busy_lo == 1) check("mem_addr_start", 32'(mem_addr), 32'(0));
            if (note_valid) nv++;
            if (note_strobe) begin
                if (sb.size() == 0) begin
                    check("strobe_unexpected", 32'(note_strobe), 32'(0));
                end else begin
                    e = sb.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("play_index", 32'(play_index), 32'(e.idx));
                    check("mem_addr", 32'(mem_addr), 32'(e.idx));
                    check("octave", 32'(octave), 32'(e.word[5:4]));
                    check("note", 32'(note), 32'(e.word[3:0]));
                end
            end
        end
        check("note_valid_cycles", nv, nv_exp);
        check("strobes_pending", sb.size(), 0);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) mem[i] = 6'h00;
        mem[0] = 6'h11;
        mem[1] = 6'h23;
        mem[2] = 6'h05;
    endtask

    task automatic begin_pass();
        start = 1'b1;
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; last_addr = 4'd2;
        load_basic();
        tick();
        tick();
        check_cleared("reset");
        reset = 1'b0;

        // Reset mid-PLAY, then start right after reset is released.
        begin_pass();
        push(3, 0);
        run(4, 1, 1000, -1, 2, 1'b0);
        reset = 1'b1;
        tick();
        check_cleared("reset_mid_play");
        reset = 1'b0;

        // Basic three-note pass.
        begin_pass();
        push(3, 0); push(11, 1); push(19, 2);
        run(30, 1, 24, 25, 12, 1'b0);

        // Full 16-slot loop with wrap back to slot 0.
        for (int i = 0; i < 16; i++) mem[i] = {2'(i), 4'(i % 12)};
        loop = 1'b1;
        last_addr = 4'd15;
        begin_pass();
        for (int k = 0; k < 16; k++) push(3 + 8 * k, k);
        push(131, 0);
        run(135, 1, 1000, -1, 68, 1'b0);
        stop = 1'b1;
        tick();
        check("loop_stop_busy", 32'(busy), 32'(0));
        check("loop_stop_note_valid", 32'(note_valid), 32'(0));
        stop = 1'b0;
        loop = 1'b0;
        tick();
        check("loop_stop_done", 32'(done), 32'(0));

        // Stop during the second PLAY, then restart.
        load_basic();
        last_addr = 4'd2;
        begin_pass();
        push(3, 0); push(11, 1);
        run(12, 1, 1000, -1, 6, 1'b0);
        stop = 1'b1;
        tick();
        check("stop_busy", 32'(busy), 32'(0));
        check("stop_note_valid", 32'(note_valid), 32'(0));
        check("stop_note_strobe", 32'(note_strobe), 32'(0));
        check("stop_done", 32'(done), 32'(0));
        check("stop_hold_play_index", 32'(play_index), 32'(1));
        stop = 1'b0;
        run(18, 999, 0, -1, 0, 1'b0);
        begin_pass();
        push(3, 0); push(11, 1); push(19, 2);
        run(30, 1, 24, 25, 12, 1'b0);

        // Rest in slot 1.
        mem[1] = 6'h0C;
        begin_pass();
        push(3, 0); push(19, 2);
        run(30, 1, 24, 25, 8, 1'b0);
        mem[1] = 6'h23;

        // start with stop in IDLE is ignored.
        start = 1'b1;
        stop = 1'b1;
        cyc = 0;
        tick();
        check("start_stop_busy", 32'(busy), 32'(0));
        start = 1'b0;
        stop = 1'b0;
        run(6, 999, 0, -1, 0, 1'b0);

        // Start pulse while busy and last_addr change mid-pass leave the pass unchanged.
        last_addr = 4'd2;
        begin_pass();
        push(3, 0); push(11, 1); push(19, 2);
        run(30, 1, 24, 25, 12, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
